// File: rtl/dual_cam_sbs_reader.sv
// Side-by-side pixel source for the HDMI output stage: camera A on the left half of
// each line, camera B on the right, served one pixel per data_req from standard-read FIFOs.
//   state  | meaning
//   IDLE   | after reset, waiting for the first vsync
//   SYNC   | inside vsync, line counter parked at 0
//   ACTIVE | frame geometry latched, serving pixel requests
module dual_cam_sbs_reader #(
  parameter int                DATA_W    = 16,
  parameter int                CNT_W     = 11,
  parameter bit                VS_POL    = 1'b0,
  parameter logic [DATA_W-1:0] BLANK_PIX = 16'h0000
) (
  input  logic              pixel_clk,
  input  logic              sys_rst,
  input  logic              video_vs,
  input  logic [CNT_W-1:0]  h_disp,
  input  logic              data_req,
  input  logic              sbs_en,
  output logic [DATA_W-1:0] data_out,
  input  logic [DATA_W-1:0] fifo_a_rdata,
  input  logic              fifo_a_empty,
  output logic              fifo_a_rd_en,
  input  logic [DATA_W-1:0] fifo_b_rdata,
  input  logic              fifo_b_empty,
  output logic              fifo_b_rd_en,
  output logic              frame_start,
  output logic              underflow,
  output logic [15:0]       underflow_cnt
);

  typedef enum logic [1:0] {IDLE, SYNC, ACTIVE} state_t;

  state_t             state, state_nx;
  logic               vs_act, vs_d;
  logic [CNT_W-1:0]   h_cnt, half_w, h_disp_l;
  logic               sbs_en_l;
  logic               req_d, sel_b_d, blank_d;
  logic [DATA_W-1:0]  hold_pix;

  logic               sel_b, active_req, line_ok, sel_empty, rd_ok, starve, frame_go;

  assign vs_act     = (video_vs == VS_POL);
  assign sel_b      = sbs_en_l & (h_cnt >= half_w);
  assign active_req = (state == ACTIVE) & data_req;
  assign line_ok    = (h_disp_l != '0);
  assign sel_empty  = sel_b ? fifo_b_empty : fifo_a_empty;
  assign rd_ok      = active_req & line_ok & ~sel_empty;
  assign starve     = active_req & line_ok & sel_empty;
  assign frame_go   = (state == SYNC) & (state_nx == ACTIVE);

  assign fifo_a_rd_en = rd_ok & ~sel_b;
  assign fifo_b_rd_en = rd_ok & sel_b;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (vs_act) state_nx = SYNC;
      SYNC:    if (vs_d && !vs_act) state_nx = ACTIVE;
      ACTIVE:  if (vs_act) state_nx = SYNC;
      default: state_nx = IDLE;
    endcase
  end

  // rdata of a standard-read FIFO lands the cycle after rd_en, so the mux is driven
  // by the select/blank flags registered alongside the read.
  always_comb begin
    data_out = hold_pix;
    if (req_d) begin
      if (blank_d)      data_out = BLANK_PIX;
      else if (sel_b_d) data_out = fifo_b_rdata;
      else              data_out = fifo_a_rdata;
    end
  end

  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state         <= IDLE;
      vs_d          <= 1'b0;
      h_cnt         <= '0;
      half_w        <= '0;
      h_disp_l      <= '0;
      sbs_en_l      <= 1'b0;
      req_d         <= 1'b0;
      sel_b_d       <= 1'b0;
      blank_d       <= 1'b1;
      hold_pix      <= BLANK_PIX;
      frame_start   <= 1'b0;
      underflow     <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      state       <= state_nx;
      vs_d        <= vs_act;
      frame_start <= frame_go;
      req_d       <= data_req;
      sel_b_d     <= sel_b;
      blank_d     <= ~rd_ok;
      hold_pix    <= data_out;

      if (frame_go) begin
        h_disp_l <= h_disp;
        sbs_en_l <= sbs_en;
        half_w   <= h_disp >> 1;
      end

      if (state != ACTIVE || state_nx != ACTIVE) begin
        h_cnt <= '0;
      end else if (active_req && line_ok) begin
        if (h_cnt == h_disp_l - CNT_W'(1)) h_cnt <= '0;
        else                               h_cnt <= h_cnt + CNT_W'(1);
      end

      if (starve) begin
        underflow <= 1'b1;
        if (underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_dual_cam_sbs_reader.sv
// Directed bench for dual_cam_sbs_reader: behavioural standard-read FIFOs feed the
// DUT and each returned pixel is compared with a hand-computed value.
module tb_dual_cam_sbs_reader;

  logic        pixel_clk = 1'b0;
  logic        sys_rst;
  logic        video_vs;
  logic [10:0] h_disp;
  logic        data_req;
  logic        sbs_en;
  logic [15:0] data_out;
  logic [15:0] fifo_a_rdata, fifo_b_rdata;
  logic        fifo_a_empty, fifo_b_empty;
  logic        fifo_a_rd_en, fifo_b_rd_en;
  logic        frame_start;
  logic        underflow;
  logic [15:0] underflow_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mem_a [0:255];
  logic [15:0] mem_b [0:255];
  logic [7:0]  wr_a = 8'd0, wr_b = 8'd0;
  logic [7:0]  rd_a = 8'd0, rd_b = 8'd0;
  int          rd_cnt_a = 0, rd_cnt_b = 0, fs_cnt = 0;
  int          base_a, base_b, base_fs;

  always #5 pixel_clk = ~pixel_clk;

  dual_cam_sbs_reader dut (
    .pixel_clk     (pixel_clk),
    .sys_rst       (sys_rst),
    .video_vs      (video_vs),
    .h_disp        (h_disp),
    .data_req      (data_req),
    .sbs_en        (sbs_en),
    .data_out      (data_out),
    .fifo_a_rdata  (fifo_a_rdata),
    .fifo_a_empty  (fifo_a_empty),
    .fifo_a_rd_en  (fifo_a_rd_en),
    .fifo_b_rdata  (fifo_b_rdata),
    .fifo_b_empty  (fifo_b_empty),
    .fifo_b_rd_en  (fifo_b_rd_en),
    .frame_start   (frame_start),
    .underflow     (underflow),
    .underflow_cnt (underflow_cnt)
  );

  assign fifo_a_empty = (rd_a == wr_a);
  assign fifo_b_empty = (rd_b == wr_b);

  initial begin
    fifo_a_rdata = 16'hDEAD;
    fifo_b_rdata = 16'hBEEF;
  end

  always @(posedge pixel_clk) begin
    if (fifo_a_rd_en) begin
      fifo_a_rdata <= mem_a[rd_a];
      rd_a         <= rd_a + 8'd1;
      rd_cnt_a     <= rd_cnt_a + 1;
    end
    if (fifo_b_rd_en) begin
      fifo_b_rdata <= mem_b[rd_b];
      rd_b         <= rd_b + 8'd1;
      rd_cnt_b     <= rd_cnt_b + 1;
    end
    if (frame_start) fs_cnt <= fs_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_a(input logic [15:0] v);
    mem_a[wr_a] = v;
    wr_a = wr_a + 8'd1;
  endtask

  task automatic push_b(input logic [15:0] v);
    mem_b[wr_b] = v;
    wr_b = wr_b + 8'd1;
  endtask

  task automatic pix(input string tag, input logic [15:0] exp);
    @(negedge pixel_clk);
    data_req = 1'b1;
    @(posedge pixel_clk);
    #1;
    chk(tag, data_out, exp);
  endtask

  task automatic req_off();
    @(negedge pixel_clk);
    data_req = 1'b0;
  endtask

  task automatic vs_pulse();
    @(negedge pixel_clk);
    video_vs = 1'b0;
    repeat (2) @(negedge pixel_clk);
    video_vs = 1'b1;
    repeat (3) @(posedge pixel_clk);
  endtask

  task automatic snap();
    @(negedge pixel_clk);
    base_a  = rd_cnt_a;
    base_b  = rd_cnt_b;
    base_fs = fs_cnt;
  endtask

  initial begin
    logic [15:0] t1_exp [8];
    logic [15:0] t2_exp [8];
    t1_exp = '{16'hA000, 16'hA001, 16'hA002, 16'hA003,
               16'hB000, 16'hB001, 16'hB002, 16'hB003};
    t2_exp = '{16'hA100, 16'hA101, 16'hA102,
               16'hB100, 16'hB101, 16'hB102, 16'hB103, 16'hA103};

    sys_rst  = 1'b1;
    video_vs = 1'b1;
    h_disp   = 11'd8;
    data_req = 1'b0;
    sbs_en   = 1'b1;
    repeat (3) @(posedge pixel_clk);
    #1;
    chk("rst_data_out", data_out, 16'h0000);
    chk("rst_outputs", {frame_start, underflow, fifo_a_rd_en, fifo_b_rd_en}, 4'b0000);
    chk("rst_uf_cnt", underflow_cnt, 16'd0);
    @(negedge pixel_clk);
    sys_rst = 1'b0;

    // 1: h_disp 8, side-by-side
    for (int i = 0; i < 4; i++) begin
      push_a(16'hA000 + 16'(i));
      push_b(16'hB000 + 16'(i));
    end
    snap();
    vs_pulse();
    for (int i = 0; i < 8; i++) pix($sformatf("t1_pix%0d", i), t1_exp[i]);
    req_off();
    chk("t1_rd_a", rd_cnt_a - base_a, 4);
    chk("t1_rd_b", rd_cnt_b - base_b, 4);
    chk("t1_fs", fs_cnt - base_fs, 1);
    chk("t1_uf", underflow, 1'b0);

    // 2: odd width, B takes the extra pixel, then the line wraps back to A
    for (int i = 0; i < 4; i++) begin
      push_a(16'hA100 + 16'(i));
      push_b(16'hB100 + 16'(i));
    end
    h_disp = 11'd7;
    vs_pulse();
    for (int i = 0; i < 8; i++) pix($sformatf("t2_pix%0d", i), t2_exp[i]);
    req_off();

    // 3: camera A full width while B holds data
    for (int i = 0; i < 8; i++) push_a(16'hA200 + 16'(i));
    push_b(16'hB200);
    h_disp = 11'd8;
    sbs_en = 1'b0;
    snap();
    vs_pulse();
    for (int i = 0; i < 8; i++) pix($sformatf("t3_pix%0d", i), 16'hA200 + 16'(i));
    req_off();
    chk("t3_rd_b", rd_cnt_b - base_b, 0);
    chk("t3_rd_a", rd_cnt_a - base_a, 8);
    wr_b = rd_b;

    // 4: B starved for the right half
    for (int i = 0; i < 4; i++) push_a(16'hA300 + 16'(i));
    sbs_en = 1'b1;
    snap();
    vs_pulse();
    for (int i = 0; i < 4; i++) pix($sformatf("t4_pix%0d", i), 16'hA300 + 16'(i));
    for (int i = 4; i < 8; i++) pix($sformatf("t4_pix%0d", i), 16'h0000);
    req_off();
    chk("t4_uf", underflow, 1'b1);
    chk("t4_uf_cnt", underflow_cnt, 16'd4);
    chk("t4_rd_b", rd_cnt_b - base_b, 0);

    // 5: vsync mid-line restarts the line at A
    for (int i = 0; i < 7; i++) push_a(16'hA400 + 16'(i));
    push_b(16'hB400);
    for (int i = 0; i < 3; i++) pix($sformatf("t5_pre%0d", i), 16'hA400 + 16'(i));
    req_off();
    snap();
    vs_pulse();
    chk("t5_fs", fs_cnt - base_fs, 1);
    for (int i = 0; i < 4; i++) pix($sformatf("t5_post%0d", i), 16'hA403 + 16'(i));
    pix("t5_post4", 16'hB400);
    req_off();
    chk("t5_uf_cnt", underflow_cnt, 16'd4);

    // 6: asynchronous reset in the middle of a line, then requests before any vsync
    push_a(16'hA500);
    push_b(16'hB401);
    @(negedge pixel_clk);
    data_req = 1'b1;
    #1;
    chk("t6_pre_rd_b", fifo_b_rd_en, 1'b1);
    #1;
    sys_rst = 1'b1;
    #1;
    chk("t6_rst_data_out", data_out, 16'h0000);
    chk("t6_rst_rd_en", {fifo_a_rd_en, fifo_b_rd_en}, 2'b00);
    chk("t6_rst_flags", {frame_start, underflow}, 2'b00);
    chk("t6_rst_uf_cnt", underflow_cnt, 16'd0);
    @(negedge pixel_clk);
    data_req = 1'b0;
    @(negedge pixel_clk);
    sys_rst = 1'b0;
    snap();
    for (int i = 0; i < 3; i++) pix($sformatf("t6_idle%0d", i), 16'h0000);
    req_off();
    chk("t6_idle_rd", (rd_cnt_a - base_a) + (rd_cnt_b - base_b), 0);
    chk("t6_idle_uf_cnt", underflow_cnt, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
